// File: rtl/hex_display_scan.sv
// Time-multiplexed hex display scanner: cycles through NUM_DIGITS digits with an
// all-off guard between slots and optional leading-zero suppression.
module hex_display_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int BLANK_CYC  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [3:0]              num,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  // state | meaning
  // BLANK | all digits off, guard between slots
  // SHOW  | one digit lit (or held dark if suppressed)
  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [3:0]              num_q, num_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_start_q, frame_start_d;

  logic [4*NUM_DIGITS-1:0] src;
  logic [NUM_DIGITS-1:0]   zero_above;
  logic [3:0]              sel_nib;
  logic [NUM_DIGITS-1:0]   show_en;

  // A load coinciding with the slot start must be displayed immediately.
  assign src = load ? value : shadow_q;

  always_comb begin
    zero_above = '0;
    zero_above[NUM_DIGITS-1] = (src[4*NUM_DIGITS-1 -: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] && (src[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    sel_nib = 4'h0;
    show_en = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_nib = src[4*i +: 4];
        if (!(blank_lz && (i != 0) && zero_above[i])) show_en[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    num_d         = num_q;
    digit_en_d    = digit_en_q;
    frame_start_d = 1'b0;
    shadow_d      = load ? value : shadow_q;
    case (state_q)
      ST_BLANK: begin
        digit_en_d = '1;
        if (cnt_q == BLANK_LAST) begin
          cnt_d         = '0;
          state_d       = ST_SHOW;
          num_d         = sel_nib;
          digit_en_d    = show_en;
          frame_start_d = (idx_q == '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SHOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d      = '0;
          state_d    = ST_BLANK;
          digit_en_d = '1;
          idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      num_q         <= 4'h0;
      digit_en_q    <= '1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      num_q         <= num_d;
      digit_en_q    <= digit_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign num         = num_q;
  assign digit_en    = digit_en_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Scoreboard bench for hex_display_scan with NUM_DIGITS=4, DIV=4, BLANK_CYC=1:
// stimulus queues per-cycle expectations, a negedge monitor pops and compares.
module tb_hex_display_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  num;
  logic [3:0]  digit_en;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int slot_no = 0;

  typedef struct packed {
    logic [3:0] num;
    logic [3:0] en;
    logic       fs;
    logic       chk_num;
  } exp_t;

  exp_t q[$];

  hex_display_scan #(.NUM_DIGITS(4), .DIV(4), .BLANK_CYC(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .blank_lz   (blank_lz),
    .num        (num),
    .digit_en   (digit_en),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected sequence for one frame: 4 SHOW cycles then 1 BLANK cycle per digit.
  // disp holds the nibble each slot must show; lit marks digits expected to light.
  task automatic push_frame(input logic [15:0] disp, input logic [3:0] lit, input int n);
    int   k;
    exp_t e;
    k = 0;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 5; c++) begin
        if (k < n) begin
          if (c < 4) begin
            e.num     = disp[4*d +: 4];
            e.en      = lit[d] ? 4'(~(4'b0001 << d)) : 4'hF;
            e.fs      = (d == 0 && c == 0);
            e.chk_num = 1'b1;
          end else begin
            e.num     = 4'h0;
            e.en      = 4'hF;
            e.fs      = 1'b0;
            e.chk_num = 1'b0;
          end
          q.push_back(e);
        end
        k++;
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("c%0d digit_en", slot_no), {4'h0, digit_en}, {4'h0, e.en});
      chk($sformatf("c%0d frame_start", slot_no), {7'h0, frame_start}, {7'h0, e.fs});
      if (e.chk_num) chk($sformatf("c%0d num", slot_no), {4'h0, num}, {4'h0, e.num});
      slot_no++;
    end
  end

  always @(negedge clk) begin
    chk("one_digit_low", 8'($countones(~digit_en) > 1), 8'd0);
  end

  initial begin
    int nfs;
    int last;
    reset    = 1'b1;
    load     = 1'b1;
    value    = 16'h1A2F;
    blank_lz = 1'b0;
    step(2);
    chk("reset num", {4'h0, num}, 8'h00);
    chk("reset digit_en", {4'h0, digit_en}, 8'h0F);
    chk("reset frame_start", {7'h0, frame_start}, 8'h00);

    // Load on the first edge after release; two full frames.
    reset = 1'b0;
    push_frame(16'h1A2F, 4'b1111, 20);
    push_frame(16'h1A2F, 4'b1111, 20);
    step(1); load = 1'b0;
    step(39);

    value = 16'h0005; blank_lz = 1'b1; load = 1'b1;
    push_frame(16'h0005, 4'b0001, 20);
    step(1); load = 1'b0;
    step(19);

    value = 16'h0000; load = 1'b1;
    push_frame(16'h0000, 4'b0001, 20);
    step(1); load = 1'b0;
    step(19);

    value = 16'h0300; load = 1'b1;
    push_frame(16'h0300, 4'b0111, 20);
    step(1); load = 1'b0;
    step(19);

    // Load BEEF during digit 1's 2nd SHOW cycle: digit 1 keeps 3, later slots take BEEF.
    blank_lz = 1'b0; value = 16'h1234; load = 1'b1;
    push_frame(16'hBE34, 4'b1111, 20);
    step(1); load = 1'b0;
    step(6);
    value = 16'hBEEF; load = 1'b1;
    step(1); load = 1'b0;
    step(12);
    push_frame(16'hBEEF, 4'b1111, 20);
    step(20);

    // Reset during digit 2's 3rd SHOW cycle.
    value = 16'h1234; load = 1'b1;
    push_frame(16'h1234, 4'b1111, 13);
    step(1); load = 1'b0;
    step(12);
    reset = 1'b1;
    #1;
    chk("async reset digit_en", {4'h0, digit_en}, 8'h0F);
    chk("async reset num", {4'h0, num}, 8'h00);
    chk("async reset frame_start", {7'h0, frame_start}, 8'h00);
    step(2);
    chk("held reset digit_en", {4'h0, digit_en}, 8'h0F);
    reset = 1'b0;
    push_frame(16'h0000, 4'b1111, 20);
    step(20);

    // Free run: frame_start must pulse every 20 cycles.
    nfs  = 0;
    last = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_start) begin
        if (last >= 0) chk("frame_start spacing", 8'(i - last), 8'd20);
        last = i;
        nfs++;
      end
    end
    chk("frame_start count", 8'(nfs), 8'd5);
    chk("scoreboard drained", 8'(q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_scan.md
HEX_DISPLAY_SCAN -- requirements
Module: hex_display_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed hex digits; legal range 1..8.
REQ-002 Parameter DIV, default 50000, SHOW-phase length per digit in clk cycles; legal range >=1.
REQ-003 Parameter BLANK_CYC, default 2, all-off guard length between digits in clk cycles; legal range >=1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 value  input  4*NUM_DIGITS  display word; nibble i (bits 4i+3:4i) maps to digit i, where digit 0 is the rightmost digit.
REQ-007 load  input  1  captures value into the shadow register on the clk edge where it is high.
REQ-008 blank_lz  input  1  enables leading-zero suppression when high.
REQ-009 num  output  4  registered nibble that feeds the team's hex-to-7-segment decoder.
REQ-010 digit_en  output  NUM_DIGITS  registered, active-low digit enables; bit i drives digit i.
REQ-011 frame_start  output  1  registered one-cycle pulse marking the start of digit 0's SHOW phase.

Function
REQ-012 The block shall hold a shadow register; load=1 shall write value into it; load=0 shall leave it unchanged.
REQ-013 The block shall use a two-state FSM {BLANK, SHOW}, one cycle counter cnt, and a digit index idx in 0..NUM_DIGITS-1.
REQ-014 In BLANK, digit_en shall be all ones, and cnt shall increment each cycle; at cnt==BLANK_CYC-1 the FSM shall clear cnt and enter SHOW.
REQ-015 On the BLANK->SHOW edge, num shall load nibble idx and digit_en shall load ~(1<<idx), unless that digit is suppressed (REQ-018), in which case digit_en shall stay all ones.
REQ-016 If load=1 on the BLANK->SHOW edge, the nibble and suppression decision shall come from the value input, not the old shadow.
REQ-017 In SHOW, num and digit_en shall stay stable and cnt shall increment; at cnt==DIV-1 the FSM shall clear cnt, enter BLANK, drive digit_en to all ones, and advance idx (NUM_DIGITS-1 wraps to 0).
REQ-018 When blank_lz=1, digit i>0 shall be suppressed if nibbles i..NUM_DIGITS-1 are all zero; digit 0 shall never be suppressed; when blank_lz=0, no digit shall be suppressed.
REQ-019 A suppressed slot shall keep full slot timing, and num shall still be driven with the nibble (0).
REQ-020 A load during SHOW shall not change num or digit_en until the next BLANK->SHOW edge.
REQ-021 frame_start shall be 1 for exactly the cycle after a BLANK->SHOW edge with idx==0, and 0 otherwise.
REQ-022 Digit period shall be BLANK_CYC+DIV cycles; frame period shall be NUM_DIGITS*(BLANK_CYC+DIV) cycles.
REQ-023 Two digit_en bits shall never be low simultaneously in any cycle.
REQ-024 Counter width shall be sized for max(DIV, BLANK_CYC) with no overflow; cnt shall never exceed its phase limit.

Reset
REQ-025 While reset=1, state shall be BLANK, with cnt=0, idx=0, shadow=0, num=0, digit_en=all ones, frame_start=0, all asynchronously.
REQ-026 Reset asserted mid-SHOW shall immediately force digit_en to all ones.
REQ-027 After reset release, the first SHOW phase (digit 0) shall begin BLANK_CYC cycles later.

Verification (NUM_DIGITS=4, DIV=4, BLANK_CYC=1)
REQ-028 Release reset with load=1, value=16'h1A2F, blank_lz=0 on the first edge -> (num, digit_en) sequence (F,1110), (2,1101), (A,1011), (1,0111), each held 4 cycles and separated by 1 cycle of digit_en=1111; repeats every 20 cycles.
REQ-029 value=16'h0005, blank_lz=1 -> digit 0 shows 5 with 1110; the slots for digits 1-3 keep digit_en=1111 for the full 20-cycle frame.
REQ-030 value=16'h0000, blank_lz=1 -> only digit 0 lights, showing num=0; value=16'h0300 -> digits 0, 1 and 2 light, digit 3 is suppressed.
REQ-031 Pulse load with 16'hBEEF in the 2nd SHOW cycle of digit 1 (old value 16'h1234) -> num stays 3 until the BLANK; the next slot shows E with 1011.
REQ-032 Assert reset in the 3rd SHOW cycle of digit 2 -> digit_en=1111 and num=0 in the same cycle; after release, the first SHOW is digit 0 showing num=0 (value was not reloaded).
REQ-033 Free-run 100 cycles -> frame_start pulses exactly 5 times, 20 cycles apart; a checker confirms REQ-023 on every cycle.
